// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types: shared definitions for the RV32I pipeline control slice.
//   pipe_ctrl_state_t : stall-controller state (RUN = 0, WAIT = 1).
//   pipe_ctrl_t       : bundle of stage-register load/flush/bubble controls.
//   REG_IDX_W         : width of an architectural register index.
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic ld_pc;
        logic ld_if_id;
        logic ld_id_ex;
        logic ld_ex_mem;
        logic ld_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic bubble_id_ex;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit: combinational load-use hazard detector.
//   id_rs1, id_rs2 : decode-stage source register indices
//   ex_rd          : EX-stage destination register index
//   ex_is_load     : EX-stage instruction is a load
//   ex_valid       : EX-stage instruction is valid
//   load_use       : decode needs a value the EX-stage load has not produced
// ---------------------------------------------------------------------------
module hazard_unit
    import rv32i_types::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_valid,
    output logic                 load_use
);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    always_comb begin
        load_use = ex_valid & ex_is_load & (ex_rd != 5'd0)
                 & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl: stall/flush/bubble controller for a 5-stage RV32I pipeline.
//
// Ports
//   clk, rst (sync, active-high)
//   imem_read/imem_resp, dmem_req/dmem_resp : memory handshake status
//   id_rs1, id_rs2, ex_rd, ex_is_load, ex_valid : load-use hazard inputs
//   br_taken      : EX resolved a taken branch/jump
//   ld_*          : stage-register load enables (combinational)
//   flush_if_id, flush_id_ex, bubble_id_ex : stage valid-bit clears
//   ctrl_state    : 0 = RUN, 1 = WAIT
//   stall_cycles, bubble_count, flush_count : saturating performance counters
//
// Configuration
//   PIPE_CTRL_PERF_EN : when defined, the performance counters are built;
//                       otherwise the counter ports are tied to zero.
//
// Priority of control decisions: freeze > br_taken > load_use.
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_valid,
    input  logic             br_taken,
    output logic             ld_pc,
    output logic             ld_if_id,
    output logic             ld_id_ex,
    output logic             ld_ex_mem,
    output logic             ld_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bubble_id_ex,
    output logic             ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    pipe_ctrl_state_t state_r;
    logic             i_done_r;
    logic             d_done_r;
    logic             pend_i_s;
    logic             pend_d_s;
    logic             freeze_s;
    logic             load_use_s;
    pipe_ctrl_t       ctrl_s;

    hazard_unit u_hazard_unit (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .ex_valid   (ex_valid),
        .load_use   (load_use_s)
    );

    // A response already seen during this freeze (done flag) no longer
    // counts as pending, so two overlapping misses release only when both
    // have been answered.
    always_comb begin
        pend_i_s = imem_read & ~imem_resp & ~i_done_r;
        pend_d_s = dmem_req  & ~dmem_resp & ~d_done_r;
        freeze_s = pend_i_s | pend_d_s;
    end

    // Zero-latency stage control selection
    always_comb begin
        ctrl_s = '0;
        if (rst) begin
            ctrl_s = '0;
        end else if (freeze_s) begin
            ctrl_s = '0;
        end else if (br_taken) begin
            ctrl_s.ld_pc       = 1'b1;
            ctrl_s.ld_if_id    = 1'b1;
            ctrl_s.ld_id_ex    = 1'b1;
            ctrl_s.ld_ex_mem   = 1'b1;
            ctrl_s.ld_mem_wb   = 1'b1;
            ctrl_s.flush_if_id = 1'b1;
            ctrl_s.flush_id_ex = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and IF/ID, let older stages drain, insert a bubble into EX
            ctrl_s.ld_id_ex     = 1'b1;
            ctrl_s.ld_ex_mem    = 1'b1;
            ctrl_s.ld_mem_wb    = 1'b1;
            ctrl_s.bubble_id_ex = 1'b1;
        end else begin
            ctrl_s.ld_pc     = 1'b1;
            ctrl_s.ld_if_id  = 1'b1;
            ctrl_s.ld_id_ex  = 1'b1;
            ctrl_s.ld_ex_mem = 1'b1;
            ctrl_s.ld_mem_wb = 1'b1;
        end
    end

    // Drive control outputs from the selected bundle
    always_comb begin
        ld_pc        = ctrl_s.ld_pc;
        ld_if_id     = ctrl_s.ld_if_id;
        ld_id_ex     = ctrl_s.ld_id_ex;
        ld_ex_mem    = ctrl_s.ld_ex_mem;
        ld_mem_wb    = ctrl_s.ld_mem_wb;
        flush_if_id  = ctrl_s.flush_if_id;
        flush_id_ex  = ctrl_s.flush_id_ex;
        bubble_id_ex = ctrl_s.bubble_id_ex;
        ctrl_state   = state_r;
    end

    // RUN/WAIT state and response-seen flags; reset abandons any wait
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
        end else begin
            case (state_r)
                RUN:     state_r <= freeze_s ? WAIT : RUN;
                WAIT:    state_r <= freeze_s ? WAIT : RUN;
                default: state_r <= RUN;
            endcase
            if (freeze_s) begin
                i_done_r <= i_done_r | imem_resp;
                d_done_r <= d_done_r | dmem_resp;
            end else begin
                i_done_r <= 1'b0;
                d_done_r <= 1'b0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating increment: an all-ones counter stays put
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    // Performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (freeze_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (ctrl_s.bubble_id_ex) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end
            if (ctrl_s.flush_if_id) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign bubble_count = bubble_cnt_r;
    assign flush_count  = flush_cnt_r;
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign bubble_count = {CNT_W{1'b0}};
    assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl: directed-vector scoreboard bench for pipeline_ctrl.
// Each vector is driven 1 time unit after a rising edge and its expected
// outputs are queued; a monitor samples on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             imem_read, imem_resp, dmem_req, dmem_resp;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             ex_is_load, ex_valid, br_taken;
    logic             ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb;
    logic             flush_if_id, flush_id_ex, bubble_id_ex, ctrl_state;
    logic [CNT_W-1:0] stall_cycles, bubble_count, flush_count;

    typedef struct {
        int          id;
        logic [8:0]  outs;
        logic        chk;
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] f;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_resp    (imem_resp),
        .dmem_req     (dmem_req),
        .dmem_resp    (dmem_resp),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_valid     (ex_valid),
        .br_taken     (br_taken),
        .ld_pc        (ld_pc),
        .ld_if_id     (ld_if_id),
        .ld_id_ex     (ld_id_ex),
        .ld_ex_mem    (ld_ex_mem),
        .ld_mem_wb    (ld_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .bubble_id_ex (bubble_id_ex),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles),
        .bubble_count (bubble_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] L = 5'b11111;
    localparam logic [4:0] B = 5'b00111;
    localparam logic [4:0] Z = 5'b00000;

    task automatic step(input int id, input logic r, input logic ir, input logic is,
                        input logic dr, input logic ds, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic ld,
                        input logic v, input logic brt, input logic [4:0] eld,
                        input logic [2:0] efl, input logic est, input logic chk,
                        input int es, input int eb, input int ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; imem_read = ir; imem_resp = is; dmem_req = dr; dmem_resp = ds;
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_is_load = ld; ex_valid = v;
        br_taken = brt;
        e.id   = id;
        e.outs = {eld, efl, est};
        e.chk  = chk;
`ifdef PIPE_CTRL_PERF_EN
        e.s = 32'(es); e.b = 32'(eb); e.f = 32'(ef);
`else
        e.s = 32'd0; e.b = 32'd0; e.f = 32'd0;
`endif
        sb_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    initial begin
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
                       flush_if_id, flush_id_ex, bubble_id_ex, ctrl_state};
                checks++;
                if (act !== e.outs) begin
                    errors++;
                    $display("FAIL ctrl vec%0d: got %b expected %b", e.id, act, e.outs);
                end
                if (e.chk) begin
                    checks++;
                    if (stall_cycles !== e.s || bubble_count !== e.b || flush_count !== e.f) begin
                        errors++;
                        $display("FAIL counters vec%0d: got s=%0d b=%0d f=%0d expected s=%0d b=%0d f=%0d",
                                 e.id, stall_cycles, bubble_count, flush_count, e.s, e.b, e.f);
                    end
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b1; imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_is_load = 1'b0; ex_valid = 1'b0;
        br_taken = 1'b0;
        repeat (2) @(posedge clk);
        //   id rst ir is dr ds rs1 rs2 rd ld v br  eld  efl  st chk s b f
        step( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 0, 1, 0, 0, 0);
        step( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L, 3'b000, 0, 1, 0, 0, 0);
        // I-cache miss answered after three frozen cycles
        step( 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 0, 0, 0, 0, 0);
        step( 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 1, 0, 0, 0, 0);
        step( 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 1, 0, 0, 0, 0);
        step( 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, L, 3'b000, 1, 1, 3, 0, 0);
        step( 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L, 3'b000, 0, 1, 3, 0, 0);
        // Same-cycle responses are not a stall
        step( 7, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, L, 3'b000, 0, 0, 0, 0, 0);
        // Overlapping misses: imem answered first, held by i_done
        step( 8, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 0, 0, 0, 0, 0);
        step( 9, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 1, 0, 0, 0, 0);
        step(10, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 1, 0, 0, 0, 0);
        step(11, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 1, 0, 0, 0, 0);
        step(12, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, L, 3'b000, 1, 1, 7, 0, 0);
        // Done flags cleared: new requests freeze again
        step(13, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 0, 0, 0, 0, 0);
        step(14, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, L, 3'b000, 1, 1, 8, 0, 0);
        step(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L, 3'b000, 0, 0, 0, 0, 0);
        // Branch during freeze takes effect on first unfrozen cycle
        step(16, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z, 3'b000, 0, 0, 0, 0, 0);
        step(17, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, L, 3'b110, 1, 0, 0, 0, 0);
        // Load-use on rs2
        step(18, 0, 0, 0, 0, 0, 3, 5, 5, 1, 1, 0, B, 3'b001, 0, 1, 9, 0, 1);
        step(19, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L, 3'b000, 0, 1, 9, 1, 1);
        // No hazard cases: x0 destination, invalid EX, non-load
        step(20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, L, 3'b000, 0, 0, 0, 0, 0);
        step(21, 0, 0, 0, 0, 0, 7, 0, 7, 1, 0, 0, L, 3'b000, 0, 0, 0, 0, 0);
        step(22, 0, 0, 0, 0, 0, 7, 2, 7, 1, 1, 0, B, 3'b001, 0, 0, 0, 0, 0);
        step(23, 0, 0, 0, 0, 0, 7, 0, 7, 0, 1, 0, L, 3'b000, 0, 0, 0, 0, 0);
        // Branch beats load-use
        step(24, 0, 0, 0, 0, 0, 9, 0, 9, 1, 1, 1, L, 3'b110, 0, 0, 0, 0, 0);
        step(25, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L, 3'b000, 0, 1, 9, 2, 2);
        // Freeze beats load-use, then bubble once unfrozen
        step(26, 0, 0, 0, 1, 0, 4, 0, 4, 1, 1, 0, Z, 3'b000, 0, 0, 0, 0, 0);
        step(27, 0, 0, 0, 1, 1, 4, 0, 4, 1, 1, 0, B, 3'b001, 1, 0, 0, 0, 0);
        // Reset pulsed mid-WAIT with i_done set
        step(28, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 0, 0, 0, 0, 0);
        step(29, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, Z, 3'b000, 1, 0, 0, 0, 0);
        step(30, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, Z, 3'b000, 1, 1, 12, 3, 2);
        step(31, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, Z, 3'b000, 0, 1, 0, 0, 0);
        step(32, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, L, 3'b000, 1, 0, 0, 0, 0);
        step(33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L, 3'b000, 0, 1, 1, 0, 0);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
